// File: rtl/draw_pkg.sv
// Shared definitions for the draw engine: command word width and display-list opcodes,
// used by the register block, the command FIFO and the VRAM controller.
package draw_pkg;

    localparam int CMD_W = 32;

    localparam logic [7:0] OP_NOP         = 8'h00;
    localparam logic [7:0] OP_EODL        = 8'h0F;
    localparam logic [7:0] OP_SETFRAME    = 8'h20;
    localparam logic [7:0] OP_SETDRAWAREA = 8'h21;
    localparam logic [7:0] OP_SETFCOLOR   = 8'h23;
    localparam logic [7:0] OP_PATBLT      = 8'h81;

    // Opcode lives in the top byte of the first word of each display-list command.
    function automatic logic [7:0] cmd_opcode(input logic [CMD_W-1:0] word);
        return word[CMD_W-1 -: 8];
    endfunction

endpackage

// File: rtl/draw_cmdfifo_ram.sv
// Simple dual-port command storage: one write port, one registered synchronous read port.
// No reset on the array or read register so it maps onto block RAM.
module draw_cmdfifo_ram #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 10
) (
    input  logic              i_clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic              i_re,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [0:(1<<ADDR_W)-1];
    logic [DATA_W-1:0] r_q;

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        if (i_re) begin
            r_q <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_q;

endmodule

// File: rtl/draw_cmdfifo.sv
// Display-list command FIFO between the CPU register port and the draw VRAM controller.
// Optional build macro DRAW_CMDFIFO_PEAK_EN adds the CMD_PEAK high-water-mark output.
module draw_cmdfifo
    import draw_pkg::*;
#(
    parameter int DATA_W     = CMD_W,
    parameter int DEPTH_LOG2 = 10
) (
    input  logic                  CLK,
    input  logic                  ARST,
    input  logic                  CMD_WR_EN,
    input  logic [DATA_W-1:0]     CMD_WDATA,
    input  logic                  CMD_RD_EN,
    output logic [DATA_W-1:0]     CMD_RDATA,
    output logic                  CMD_EMPTY,
    output logic                  CMD_FULL,
    output logic [DEPTH_LOG2:0]   CMD_CNT,
    input  logic                  CMD_CLR,
    input  logic                  ERR_CLR,
    output logic                  ERR_OVF,
    output logic                  ERR_UDF
`ifdef DRAW_CMDFIFO_PEAK_EN
    ,
    output logic [DEPTH_LOG2:0]   CMD_PEAK
`endif
);

    localparam logic [DEPTH_LOG2:0]   CNT_FULL = {1'b1, {DEPTH_LOG2{1'b0}}};
    localparam logic [DEPTH_LOG2:0]   CNT_ONE  = {{DEPTH_LOG2{1'b0}}, 1'b1};
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = {{(DEPTH_LOG2-1){1'b0}}, 1'b1};

    logic [DEPTH_LOG2-1:0] r_wr_ptr;
    logic [DEPTH_LOG2-1:0] r_rd_ptr;
    logic [DEPTH_LOG2:0]   r_cnt;
    logic                  r_empty;
    logic                  r_full;
    logic                  r_ovf;
    logic                  r_udf;
    logic                  r_rd_seen;

    logic                  w_push;
    logic                  w_pop;
    logic                  w_ovf_evt;
    logic                  w_udf_evt;
    logic [DEPTH_LOG2:0]   w_cnt_next;
    logic [DATA_W-1:0]     w_ram_rdata;

    // Flush wins over both requests; error events are judged on the registered flags only.
    assign w_push    = CMD_WR_EN & ~r_full  & ~CMD_CLR;
    assign w_pop     = CMD_RD_EN & ~r_empty & ~CMD_CLR;
    assign w_ovf_evt = CMD_WR_EN & r_full;
    assign w_udf_evt = CMD_RD_EN & r_empty;

    always_comb begin
        w_cnt_next = r_cnt;
        if (CMD_CLR) begin
            w_cnt_next = '0;
        end else begin
            case ({w_push, w_pop})
                2'b10:   w_cnt_next = r_cnt + CNT_ONE;
                2'b01:   w_cnt_next = r_cnt - CNT_ONE;
                default: w_cnt_next = r_cnt;
            endcase
        end
    end

    draw_cmdfifo_ram #(
        .DATA_W (DATA_W),
        .ADDR_W (DEPTH_LOG2)
    ) u_ram (
        .i_clk   (CLK),
        .i_we    (w_push),
        .i_waddr (r_wr_ptr),
        .i_wdata (CMD_WDATA),
        .i_re    (w_pop),
        .i_raddr (r_rd_ptr),
        .o_rdata (w_ram_rdata)
    );

    always_ff @(posedge CLK or posedge ARST) begin
        if (ARST) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_cnt     <= '0;
            r_empty   <= 1'b1;
            r_full    <= 1'b0;
            r_ovf     <= 1'b0;
            r_udf     <= 1'b0;
            r_rd_seen <= 1'b0;
        end else begin
            if (CMD_CLR) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
            end else begin
                if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
                if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
            r_cnt   <= w_cnt_next;
            r_empty <= (w_cnt_next == '0);
            r_full  <= (w_cnt_next == CNT_FULL);
            if (w_ovf_evt)    r_ovf <= 1'b1;
            else if (ERR_CLR) r_ovf <= 1'b0;
            if (w_udf_evt)    r_udf <= 1'b1;
            else if (ERR_CLR) r_udf <= 1'b0;
            if (w_pop)        r_rd_seen <= 1'b1;
        end
    end

    // The RAM read register has no reset, so present zero until the first real pop lands.
    assign CMD_RDATA = r_rd_seen ? w_ram_rdata : '0;
    assign CMD_EMPTY = r_empty;
    assign CMD_FULL  = r_full;
    assign CMD_CNT   = r_cnt;
    assign ERR_OVF   = r_ovf;
    assign ERR_UDF   = r_udf;

`ifdef DRAW_CMDFIFO_PEAK_EN
    logic [DEPTH_LOG2:0] r_peak;

    always_ff @(posedge CLK or posedge ARST) begin
        if (ARST) begin
            r_peak <= '0;
        end else if (CMD_CLR) begin
            r_peak <= '0;
        end else if (w_cnt_next > r_peak) begin
            r_peak <= w_cnt_next;
        end
    end

    assign CMD_PEAK = r_peak;
`endif

endmodule

// File: tb/tb_draw_cmdfifo.sv
// Self-checking bench for draw_cmdfifo: directed vector table, corner sequences and
// randomized traffic against a queue-based reference model.
module tb_draw_cmdfifo;
    import draw_pkg::*;

    localparam int AW    = 10;
    localparam int DEPTH = 1 << AW;

    logic          CLK = 1'b0;
    logic          ARST = 1'b1;
    logic          wr_en = 1'b0;
    logic          rd_en = 1'b0;
    logic          clr = 1'b0;
    logic          eclr = 1'b0;
    logic [31:0]   wdata = '0;
    logic [31:0]   rdata;
    logic          empty;
    logic          full;
    logic [AW:0]   cnt;
    logic          ovf;
    logic          udf;
`ifdef DRAW_CMDFIFO_PEAK_EN
    logic [AW:0]   peak;
`endif

    draw_cmdfifo #(.DATA_W(CMD_W), .DEPTH_LOG2(AW)) dut (
        .CLK       (CLK),
        .ARST      (ARST),
        .CMD_WR_EN (wr_en),
        .CMD_WDATA (wdata),
        .CMD_RD_EN (rd_en),
        .CMD_RDATA (rdata),
        .CMD_EMPTY (empty),
        .CMD_FULL  (full),
        .CMD_CNT   (cnt),
        .CMD_CLR   (clr),
        .ERR_CLR   (eclr),
        .ERR_OVF   (ovf),
        .ERR_UDF   (udf)
`ifdef DRAW_CMDFIFO_PEAK_EN
        ,
        .CMD_PEAK  (peak)
`endif
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: contents as a queue, plus last popped word, sticky flags, peak.
    logic [31:0] exp_q[$];
    logic [31:0] m_rdata;
    int          m_ovf;
    int          m_udf;
    int          m_peak;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_rdata = '0;
        m_ovf   = 0;
        m_udf   = 0;
        m_peak  = 0;
    endtask

    task automatic model_edge(input bit wr, input logic [31:0] wd, input bit rd,
                              input bit c, input bit ec);
        bit was_full;
        bit was_empty;
        was_full  = (exp_q.size() == DEPTH);
        was_empty = (exp_q.size() == 0);
        if (c) begin
            exp_q.delete();
            m_peak = 0;
        end else begin
            if (rd && !was_empty) m_rdata = exp_q.pop_front();
            if (wr && !was_full)  exp_q.push_back(wd);
            if (exp_q.size() > m_peak) m_peak = exp_q.size();
        end
        if (wr && was_full) m_ovf = 1;
        else if (ec)        m_ovf = 0;
        if (rd && was_empty) m_udf = 1;
        else if (ec)         m_udf = 0;
    endtask

    task automatic cycle(input bit wr, input logic [31:0] wd, input bit rd,
                         input bit c, input bit ec);
        wr_en = wr;
        wdata = wd;
        rd_en = rd;
        clr   = c;
        eclr  = ec;
        @(posedge CLK);
        #1;
        model_edge(wr, wd, rd, c, ec);
        wr_en = 1'b0;
        rd_en = 1'b0;
        clr   = 1'b0;
        eclr  = 1'b0;
    endtask

    task automatic check_model(input string tag);
        chk({tag, ".cnt"},   32'(cnt),   32'(exp_q.size()));
        chk({tag, ".empty"}, 32'(empty), 32'(exp_q.size() == 0));
        chk({tag, ".full"},  32'(full),  32'(exp_q.size() == DEPTH));
        chk({tag, ".rdata"}, rdata,      m_rdata);
        chk({tag, ".ovf"},   32'(ovf),   32'(m_ovf));
        chk({tag, ".udf"},   32'(udf),   32'(m_udf));
`ifdef DRAW_CMDFIFO_PEAK_EN
        chk({tag, ".peak"},  32'(peak),  32'(m_peak));
`endif
    endtask

    typedef struct {
        bit          wr;
        logic [31:0] wd;
        bit          rd;
        bit          ec;
        logic [31:0] cnt;
        logic [31:0] empty;
        logic [31:0] rdata;
        logic [31:0] ovf;
        logic [31:0] udf;
    } vec_t;

    vec_t tbl[10];

    initial begin
        tbl[0] = '{1'b1, 32'h0000_0020, 1'b0, 1'b0, 1, 0, 32'h0,         0, 0};
        tbl[1] = '{1'b1, 32'h1000_0000, 1'b0, 1'b0, 2, 0, 32'h0,         0, 0};
        tbl[2] = '{1'b1, 32'h0280_01E0, 1'b0, 1'b0, 3, 0, 32'h0,         0, 0};
        tbl[3] = '{1'b0, 32'h0,         1'b1, 1'b0, 2, 0, 32'h0000_0020, 0, 0};
        tbl[4] = '{1'b0, 32'h0,         1'b1, 1'b0, 1, 0, 32'h1000_0000, 0, 0};
        tbl[5] = '{1'b0, 32'h0,         1'b1, 1'b0, 0, 1, 32'h0280_01E0, 0, 0};
        tbl[6] = '{1'b0, 32'h0,         1'b1, 1'b0, 0, 1, 32'h0280_01E0, 0, 1};
        tbl[7] = '{1'b0, 32'h0,         1'b0, 1'b1, 0, 1, 32'h0280_01E0, 0, 0};
        tbl[8] = '{1'b1, 32'h8100_0000, 1'b1, 1'b0, 1, 0, 32'h0280_01E0, 0, 1};
        tbl[9] = '{1'b0, 32'h0,         1'b1, 1'b1, 0, 1, 32'h8100_0000, 0, 0};

        model_reset();
        #22;
        chk("reset.cnt",   32'(cnt),   32'd0);
        chk("reset.empty", 32'(empty), 32'd1);
        chk("reset.full",  32'(full),  32'd0);
        chk("reset.rdata", rdata,      32'd0);
        chk("reset.ovf",   32'(ovf),   32'd0);
        chk("reset.udf",   32'(udf),   32'd0);
        ARST = 1'b0;

        // Directed table: basic push/pop order, underflow, error clear, empty+push+pop.
        for (int i = 0; i < 10; i++) begin
            cycle(tbl[i].wr, tbl[i].wd, tbl[i].rd, 1'b0, tbl[i].ec);
            chk($sformatf("tbl%0d.cnt", i),   32'(cnt),   tbl[i].cnt);
            chk($sformatf("tbl%0d.empty", i), 32'(empty), tbl[i].empty);
            chk($sformatf("tbl%0d.full", i),  32'(full),  32'd0);
            chk($sformatf("tbl%0d.rdata", i), rdata,      tbl[i].rdata);
            chk($sformatf("tbl%0d.ovf", i),   32'(ovf),   tbl[i].ovf);
            chk($sformatf("tbl%0d.udf", i),   32'(udf),   tbl[i].udf);
        end

        // Fill to DEPTH, overflow, drain in order.
        for (int i = 0; i < DEPTH; i++) begin
            cycle(1'b1, 32'(i), 1'b0, 1'b0, 1'b0);
            check_model("fill");
        end
        chk("fill.full", 32'(full), 32'd1);
        chk("fill.cnt",  32'(cnt),  32'(DEPTH));
        cycle(1'b1, 32'h0000_DEAD, 1'b0, 1'b0, 1'b0);
        chk("ovf.flag", 32'(ovf), 32'd1);
        chk("ovf.cnt",  32'(cnt), 32'(DEPTH));
        for (int i = 0; i < DEPTH; i++) begin
            cycle(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
            chk("drain.data", rdata, 32'(i));
        end
        chk("drain.empty", 32'(empty), 32'd1);
        cycle(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        chk("udf.flag",  32'(udf), 32'd1);
        chk("udf.rdata", rdata,    32'(DEPTH - 1));
        chk("udf.ovf",   32'(ovf), 32'd1);
        cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
        chk("eclr.ovf", 32'(ovf), 32'd0);
        chk("eclr.udf", 32'(udf), 32'd0);

        // Steady push+pop at CNT=5 across several pointer wraps.
        for (int i = 0; i < 5; i++) cycle(1'b1, $urandom, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3 * DEPTH; i++) begin
            cycle(1'b1, $urandom, 1'b1, 1'b0, 1'b0);
            check_model("wrap");
        end
        chk("wrap.cnt", 32'(cnt), 32'd5);

        // Full + push + pop: pop accepted, push rejected.
        while (exp_q.size() < DEPTH) cycle(1'b1, $urandom, 1'b0, 1'b0, 1'b0);
        check_model("refill");
        cycle(1'b1, 32'h1234_5678, 1'b1, 1'b0, 1'b0);
        chk("fullpp.cnt", 32'(cnt), 32'(DEPTH - 1));
        chk("fullpp.ovf", 32'(ovf), 32'd1);
        check_model("fullpp");

        // Flush with push and pop asserted at CNT=7.
        cycle(1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
        check_model("flush0");
        for (int i = 0; i < 7; i++) cycle(1'b1, $urandom, 1'b0, 1'b0, 1'b0);
        chk("pre_flush.cnt", 32'(cnt), 32'd7);
        cycle(1'b1, 32'hCAFE_0001, 1'b1, 1'b1, 1'b0);
        chk("flush.cnt",   32'(cnt),   32'd0);
        chk("flush.empty", 32'(empty), 32'd1);
        check_model("flush");

        // Asynchronous reset mid-fill, checked before any clock edge.
        for (int i = 0; i < 6; i++) cycle(1'b1, $urandom, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        ARST = 1'b1;
        #1;
        model_reset();
        check_model("arst");
        #2;
        ARST = 1'b0;

`ifdef DRAW_CMDFIFO_PEAK_EN
        for (int i = 0; i < 9; i++) cycle(1'b1, $urandom, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) cycle(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 2; i++) cycle(1'b1, $urandom, 1'b0, 1'b0, 1'b0);
        chk("peak.value", 32'(peak), 32'd9);
        cycle(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
        chk("peak.clr", 32'(peak), 32'd0);
`endif

        // Random traffic; flushes are issued alone so request priority stays unambiguous.
        for (int i = 0; i < 3000; i++) begin
            bit c;
            bit ec;
            bit wr;
            bit rd;
            c  = ($urandom_range(0, 99) < 2);
            ec = ($urandom_range(0, 19) == 0);
            wr = !c && ($urandom_range(0, 99) < 55);
            rd = !c && ($urandom_range(0, 99) < 50);
            cycle(wr, $urandom, rd, c, ec);
            check_model("rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
